// File: rtl/bus_select_encoder.sv
// -----------------------------------------------------------------------------
// bus_select_encoder
//
// Purpose
//   Encodes a (nominally one-hot) request vector into a registered source
//   index. When more than one request bit is set in a sampled vector, the
//   block still picks a winner. It also flags the event with a one-cycle
//   pulse, a sticky error bit and a saturating event counter.
//
//   Winner selection:
//     default build      : fixed priority, the lowest set index wins.
//     BUS_SELECT_ENC_RR_EN: round-robin. The search starts at last_grant+1
//                           and wraps modulo N_SRC. The pointer advances only
//                           on edges that actually grant (en=1, req != 0).
//
// Configuration macro
//   BUS_SELECT_ENC_RR_EN  - define to build the round-robin variant.
//
// Parameters
//   N_SRC  number of request lines
//   SEL_W  select width, 2**SEL_W >= N_SRC
//   HOLD   1: keep the last sel when nothing is requested, 0: drive 0
//   CNT_W  width of the multi-hot event counter
//
// Ports
//   clk        in   single clock, rising edge
//   clr        in   asynchronous active-high reset
//   req        in   [N_SRC-1:0] request vector, bit k requests source k
//   en         in   sample enable
//   err_clr    in   synchronous clear of multi_err / err_count
//   sel        out  [SEL_W-1:0] registered winning index
//   sel_valid  out  sel reflects a request sampled on the last enabled cycle
//   multi_hot  out  one-cycle pulse, sampled req had >= 2 bits set
//   multi_err  out  sticky multi-hot flag
//   err_count  out  [CNT_W-1:0] saturating count of multi-hot samples
//
// Timing
//   All outputs are registered. req/en are sampled on a rising edge and the
//   result is visible right after that same edge (one edge of latency).
// -----------------------------------------------------------------------------
module bus_select_encoder #(
    parameter int N_SRC = 32,
    parameter int SEL_W = 5,
    parameter int HOLD  = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_SRC-1:0] req,
    input  logic             en,
    input  logic             err_clr,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             multi_hot,
    output logic             multi_err,
    output logic [CNT_W-1:0] err_count
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    logic [SEL_W-1:0] r_sel;
    logic             r_sel_valid;
    logic             r_multi_hot;
    logic             r_multi_err;
    logic [CNT_W-1:0] r_err_count;

    // -------------------------------------------------------------------------
    // Combinational request decode
    // -------------------------------------------------------------------------
    logic             w_req_any;   // at least one request bit set
    logic             w_multi;     // two or more request bits set
    logic [SEL_W-1:0] w_win_idx;   // winning index for this sample

    // The port is exactly N_SRC bits wide. Indices at or above N_SRC therefore
    // cannot be requested, and both encoders below only ever produce indices
    // in 0..N_SRC-1, even when SEL_W could express more.
    assign w_req_any = |req;

    // Clearing the lowest set bit leaves something behind exactly when two or
    // more bits were set. This avoids building a full popcount adder tree.
    assign w_multi = |(req & (req - N_SRC'(1)));

`ifdef BUS_SELECT_ENC_RR_EN
    // -------------------------------------------------------------------------
    // Round-robin winner
    // -------------------------------------------------------------------------
    // r_ptr holds the last granted index. Reset puts it at N_SRC-1, so the
    // first search after reset starts at index 0.
    logic [SEL_W-1:0] r_ptr;
    logic             w_rr_hit;

    // base is in 0..N_SRC-1 and off is in 1..N_SRC, so one conditional
    // subtraction is enough to wrap. No general modulo is needed.
    function automatic int rr_wrap(input int base, input int off);
        int sum;
        sum = base + off;
        if (sum >= N_SRC) begin
            sum = sum - N_SRC;
        end
        return sum;
    endfunction

    always_comb begin
        w_win_idx = '0;
        w_rr_hit  = 1'b0;
        // Offsets run 1..N_SRC. Offset N_SRC lands back on the last grant, so
        // the previous winner is chosen again only if it is the sole requester.
        for (int o = 1; o <= N_SRC; o++) begin
            if (!w_rr_hit && req[rr_wrap(int'(r_ptr), o)]) begin
                w_win_idx = SEL_W'(rr_wrap(int'(r_ptr), o));
                w_rr_hit  = 1'b1;
            end
        end
    end

    // The pointer moves only on edges that actually grant something.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ptr <= SEL_W'(N_SRC - 1);
        end else if (en && w_req_any) begin
            r_ptr <= w_win_idx;
        end
    end
`else
    // -------------------------------------------------------------------------
    // Fixed-priority winner: the lowest set index wins
    // -------------------------------------------------------------------------
    // The scan walks from the top index down. Each later assignment overrides
    // the earlier ones, so the lowest set bit has the final say.
    always_comb begin
        w_win_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win_idx = SEL_W'(i);
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Select path: sel / sel_valid / multi_hot
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
            r_multi_hot <= 1'b0;
        end else begin
            // multi_hot is a pulse. It drops unless this edge samples a
            // multi-hot vector with en high.
            r_multi_hot <= en && w_multi;
            if (en) begin
                if (w_req_any) begin
                    r_sel       <= w_win_idx;
                    r_sel_valid <= 1'b1;
                end else begin
                    r_sel_valid <= 1'b0;
                    if (HOLD == 0) begin
                        r_sel <= '0;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Error path: sticky flag and saturating counter
    // -------------------------------------------------------------------------
    // If a new multi-hot sample and err_clr arrive on the same edge, the new
    // event wins. The clear wipes the history and this sample then counts as
    // the first event, which leaves err_count at 1 and multi_err set.
    // err_clr is not gated by en. A clear request is honoured on any edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_multi_err <= 1'b0;
            r_err_count <= '0;
        end else if (en && w_multi) begin
            r_multi_err <= 1'b1;
            if (err_clr) begin
                r_err_count <= CNT_W'(1);
            end else if (r_err_count != CNT_MAX) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end else if (err_clr) begin
            r_multi_err <= 1'b0;
            r_err_count <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign sel       = r_sel;
    assign sel_valid = r_sel_valid;
    assign multi_hot = r_multi_hot;
    assign multi_err = r_multi_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_bus_select_encoder.sv
// Testbench for bus_select_encoder.
// Three instances share one set of inputs:
//   dut    - defaults (HOLD=1, CNT_W=8)
//   dut_h0 - HOLD=0
//   dut_c2 - CNT_W=2
// A reference model computes the expected packed output for every driven
// cycle and pushes it to exp_q. Each test pops it after the edge and compares.
module tb_bus_select_encoder;

  localparam int N  = 32;
  localparam int SW = 5;
  localparam int CW = 8;
  localparam int EW = SW + 3 + CW + SW + 2;

  logic          clk = 1'b0;
  logic          clr;
  logic [N-1:0]  req;
  logic          en;
  logic          err_clr;

  logic [SW-1:0] sel, sel_h0, sel_c2;
  logic          sel_valid, sel_valid_h0, sel_valid_c2;
  logic          multi_hot, multi_hot_h0, multi_hot_c2;
  logic          multi_err, multi_err_h0, multi_err_c2;
  logic [CW-1:0] err_count, err_count_h0;
  logic [1:0]    err_count_c2;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bus_select_encoder #(.N_SRC(N), .SEL_W(SW), .HOLD(1), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .req(req), .en(en), .err_clr(err_clr),
    .sel(sel), .sel_valid(sel_valid), .multi_hot(multi_hot),
    .multi_err(multi_err), .err_count(err_count));

  bus_select_encoder #(.N_SRC(N), .SEL_W(SW), .HOLD(0), .CNT_W(CW)) dut_h0 (
    .clk(clk), .clr(clr), .req(req), .en(en), .err_clr(err_clr),
    .sel(sel_h0), .sel_valid(sel_valid_h0), .multi_hot(multi_hot_h0),
    .multi_err(multi_err_h0), .err_count(err_count_h0));

  bus_select_encoder #(.N_SRC(N), .SEL_W(SW), .HOLD(1), .CNT_W(2)) dut_c2 (
    .clk(clk), .clr(clr), .req(req), .en(en), .err_clr(err_clr),
    .sel(sel_c2), .sel_valid(sel_valid_c2), .multi_hot(multi_hot_c2),
    .multi_err(multi_err_c2), .err_count(err_count_c2));

  // Packed observation: main outputs, then HOLD=0 sel, then CNT_W=2 count.
  logic [EW-1:0] got;
  assign got = {sel, sel_valid, multi_hot, multi_err, err_count, sel_h0, err_count_c2};

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int   m_sel, m_sel_h0, m_cnt, m_cnt2, m_ptr;
  logic m_valid, m_mh, m_merr;

  function automatic int ref_winner(input logic [N-1:0] r);
    int w;
    w = 0;
`ifdef BUS_SELECT_ENC_RR_EN
    for (int k = N - 1; k >= 0; k--) begin
      if (r[(m_ptr + 1 + k) % N]) w = (m_ptr + 1 + k) % N;
    end
`else
    for (int k = N - 1; k >= 0; k--) begin
      if (r[k]) w = k;
    end
`endif
    return w;
  endfunction

  task automatic model_reset();
    m_sel = 0; m_sel_h0 = 0; m_cnt = 0; m_cnt2 = 0; m_ptr = N - 1;
    m_valid = 1'b0; m_mh = 1'b0; m_merr = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic e, input logic c);
    int w;
    logic mh_now;
    mh_now = e && ($countones(r) >= 2);
    if (e) begin
      if (r != '0) begin
        w = ref_winner(r);
        m_sel = w; m_sel_h0 = w; m_valid = 1'b1; m_ptr = w;
      end else begin
        m_valid = 1'b0; m_sel_h0 = 0;
      end
    end
    m_mh = mh_now;
    if (c) begin
      m_merr = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end
    if (mh_now) begin
      m_merr = 1'b1;
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    exp_q.push_back({SW'(m_sel), m_valid, m_mh, m_merr, CW'(m_cnt), SW'(m_sel_h0), 2'(m_cnt2)});
  endtask

  // ---------------- driver ----------------
  // Drives one cycle at the falling edge, records the expectation and
  // returns 1 time unit after the sampling edge.
  task automatic drive(input logic [N-1:0] r, input logic e, input logic c);
    @(negedge clk);
    req = r; en = e; err_clr = c;
    model_step(r, e, c);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rand_multi();
    logic [N-1:0] r;
    int a, b;
    r = N'($urandom);
    a = $urandom_range(0, N - 1);
    b = (a + $urandom_range(1, N - 1)) % N;
    r[a] = 1'b1;
    r[b] = 1'b1;
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b1; req = '0; en = 1'b0; err_clr = 1'b0;
    model_reset();
    #2;
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", got, {EW{1'b0}});
    end
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_onehot_sweep();
    logic [EW-1:0] exp;
    for (int k = 0; k < N; k++) begin
      drive(N'(1) << k, 1'b1, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || sel !== SW'(k) || sel_valid !== 1'b1 || multi_hot !== 1'b0) begin
        errors++;
        $display("FAIL onehot_sweep k=%0d: got %h (sel=%0d) expected %h (sel=%0d)", k, got, sel, exp, k);
      end
    end
  endtask

  task automatic test_priority_multi();
    logic [EW-1:0] exp;
    drive(32'h0001_0100, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || sel !== 5'd8 || multi_hot !== 1'b1 || multi_err !== 1'b1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL priority_multi: got %h sel=%0d mh=%b me=%b cnt=%0d expected %h sel=8 mh=1 me=1 cnt=1",
               got, sel, multi_hot, multi_err, err_count, exp);
    end
    drive(32'h0000_0004, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || multi_hot !== 1'b0 || multi_err !== 1'b1) begin
      errors++;
      $display("FAIL multi_pulse_drop: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_hold();
    logic [EW-1:0] exp;
    drive(N'(1) << 5, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL hold_load: got %h expected %h", got, exp);
    end
    drive('0, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || sel !== 5'd5 || sel_valid !== 1'b0 || sel_h0 !== 5'd0 || sel_valid_h0 !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: got %h sel=%0d v=%b sel_h0=%0d expected %h sel=5 v=0 sel_h0=0",
               got, sel, sel_valid, sel_h0, exp);
    end
  endtask

  task automatic test_en_low();
    logic [EW-1:0] exp;
    drive(N'(1) << 7, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL en_low_load: got %h expected %h", got, exp);
    end
    drive(32'h0000_00f0, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || sel !== 5'd7 || multi_hot !== 1'b0) begin
      errors++;
      $display("FAIL en_low_hold: got %h sel=%0d mh=%b expected %h sel=7 mh=0", got, sel, multi_hot, exp);
    end
  endtask

  task automatic test_saturation();
    logic [EW-1:0] exp;
    drive('0, 1'b1, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || multi_err !== 1'b0 || err_count !== 8'd0 || err_count_c2 !== 2'd0) begin
      errors++;
      $display("FAIL err_clear: got %h expected %h", got, exp);
    end
    for (int i = 0; i < 5; i++) begin
      drive(rand_multi(), 1'b1, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL saturate_step%0d: got %h expected %h", i, got, exp);
      end
    end
    checks++;
    if (err_count_c2 !== 2'd3 || err_count !== 8'd5) begin
      errors++;
      $display("FAIL saturate_value: got c2=%0d c8=%0d expected c2=3 c8=5", err_count_c2, err_count);
    end
    drive(rand_multi(), 1'b1, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || err_count_c2 !== 2'd1 || err_count !== 8'd1 || multi_err !== 1'b1) begin
      errors++;
      $display("FAIL clr_and_set: got %h c2=%0d c8=%0d me=%b expected %h c2=1 c8=1 me=1",
               got, err_count_c2, err_count, multi_err, exp);
    end
  endtask

`ifdef BUS_SELECT_ENC_RR_EN
  task automatic test_round_robin();
    logic [EW-1:0] exp;
    logic [SW-1:0] rr_seq [4];
    rr_seq = '{5'd0, 5'd1, 5'd4, 5'd0};
    @(negedge clk);
    clr = 1'b1;
    model_reset();
    #1 clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h0000_0013, 1'b1, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || sel !== rr_seq[i]) begin
        errors++;
        $display("FAIL round_robin step%0d: got %h sel=%0d expected %h sel=%0d", i, got, sel, exp, rr_seq[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [EW-1:0] exp;
    logic [N-1:0]  r;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = N'(1) << $urandom_range(0, N - 1);
        2: r = rand_multi();
        default: r = N'($urandom);
      endcase
      drive(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random step%0d req=%h: got %h expected %h", i, r, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [EW-1:0] exp;
    drive(32'h0010_1000, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL areset_pre_multi: got %h expected %h", got, exp);
    end
    drive(N'(1) << 9, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || sel !== 5'd9 || multi_err !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_sel: got %h sel=%0d expected %h sel=9", got, sel, exp);
    end
    // clr pulse entirely between edges while a multi-hot sample is pending
    @(negedge clk);
    req = rand_multi(); en = 1'b1; err_clr = 1'b0;
    #1 clr = 1'b1;
    #1;
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL areset_immediate: got %h expected %h", got, {EW{1'b0}});
    end
    #1 clr = 1'b0;
    model_reset();
    req = 32'h0000_0003;
    model_step(32'h0000_0003, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || sel !== 5'd0 || sel_valid !== 1'b1 || multi_hot !== 1'b1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL areset_first_sample: got %h sel=%0d expected %h sel=0", got, sel, exp);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_onehot_sweep();
    test_priority_multi();
    test_hold();
    test_en_low();
    test_saturation();
`ifdef BUS_SELECT_ENC_RR_EN
    test_round_robin();
`endif
    test_random();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_select_encoder.md
BUS_SELECT_ENCODER -- requirements
Module: bus_select_encoder

Interface
REQ-001 SHALL have parameter N_SRC, default 32, meaning the number of request lines.
REQ-002 SHALL have parameter SEL_W, default 5, meaning the select width; SEL_W SHALL satisfy 2^SEL_W >= N_SRC.
REQ-003 SHALL have parameter HOLD, default 1; 1 means hold the last sel when there is no request, 0 means drive 0.
REQ-004 SHALL have parameter CNT_W, default 8, meaning the width of the multi-hot event counter.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port req, input, N_SRC bits: the one-hot request vector; bit k requests source k.
REQ-008 SHALL have port en, input, 1 bit: sample enable.
REQ-009 SHALL have port err_clr, input, 1 bit: synchronous clear of multi_err and err_count.
REQ-010 SHALL have port sel, output, SEL_W bits: the registered encoded source index.
REQ-011 SHALL have port sel_valid, output, 1 bit: sel reflects a request sampled on the last enabled cycle.
REQ-012 SHALL have port multi_hot, output, 1 bit: one-cycle pulse when the sampled req had two or more bits set.
REQ-013 SHALL have port multi_err, output, 1 bit: sticky multi-hot flag.
REQ-014 SHALL have port err_count, output, CNT_W bits: saturating count of multi-hot samples.

Function
REQ-015 SHALL register all outputs, with latency of one clk edge from the sampled req/en to sel/sel_valid/multi_hot.
REQ-016 SHALL, with en=1 and req nonzero, load sel with the winning index and set sel_valid=1.
REQ-017 SHALL, with the default (fixed) priority, select the lowest set index as the winner.
REQ-018 SHALL, with en=1 and req=0, set sel_valid=0 and multi_hot=0; sel SHALL hold if HOLD=1 and load 0 if HOLD=0.
REQ-019 SHALL, with en=0, hold sel, sel_valid, multi_err and err_count, and force multi_hot=0.
REQ-020 SHALL, with en=1 and popcount(req)>=2, pulse multi_hot=1 for one cycle, set multi_err, and increment err_count.
REQ-021 SHALL saturate err_count at 2^CNT_W-1 with no wrap.
REQ-022 SHALL, on err_clr=1, clear multi_err to 0 and err_count to 0 on the next edge.
REQ-023 SHALL, when err_clr and a multi-hot sample occur on the same cycle, result in multi_err=1 and err_count=1 (the set wins).
REQ-024 SHALL ignore req bits at or above N_SRC when SEL_W allows wider indices; sel SHALL never exceed N_SRC-1.

Reset
REQ-025 SHALL, while clr=1, immediately force sel=0, sel_valid=0, multi_hot=0, multi_err=0, err_count=0, and the round-robin pointer to N_SRC-1.
REQ-026 SHALL, when clr asserts mid-operation, discard any pending sample; the first edge after clr deasserts SHALL sample normally.

Configuration
REQ-027 SHALL, when macro BUS_SELECT_ENC_RR_EN is defined, replace fixed priority with round-robin selection.
REQ-028 SHALL, under BUS_SELECT_ENC_RR_EN, search from last_grant+1 upward, wrapping modulo N_SRC.
REQ-029 SHALL, under BUS_SELECT_ENC_RR_EN, update last_grant only on edges where en=1 and req is nonzero.
REQ-030 SHALL, with BUS_SELECT_ENC_RR_EN undefined, contain no pointer register and behave per REQ-017.
REQ-031 SHALL apply multi-hot detection and counting identically in both configurations.

Verification
REQ-032 SHALL cover one-hot sweep: en=1, req=1<<k for k=0..31 -> sel=k one edge later, sel_valid=1, multi_hot=0.
REQ-033 SHALL cover fixed-priority multi-hot: req=32'h0001_0100 -> sel=8, multi_hot pulse, multi_err=1, err_count=1.
REQ-034 SHALL cover hold: sel=5, then req=0 -> HOLD=1: sel=5, sel_valid=0; HOLD=0: sel=0, sel_valid=0.
REQ-035 SHALL cover saturation and clear: CNT_W=2, 5 multi-hot samples -> err_count=3; err_clr with a multi-hot sample on the same cycle -> err_count=1, multi_err=1.
REQ-036 SHALL cover round-robin with BUS_SELECT_ENC_RR_EN: req=32'h0000_0013 held for 4 enabled cycles -> sel=0,1,4,0.
REQ-037 SHALL cover async reset: clr pulsed between edges while sel=9 -> all outputs 0 immediately; in RR mode the next req=32'h0000_0003 -> sel=0.
